// File: rtl/ptosda_frame.sv
// ptosda_frame - parallel-to-serial framer with a two-wire scl/sda output.
//
// Accepts one DATA_W-bit word over a valid/ready handshake and sends it as
// a frame: start condition, payload bits (MSB or LSB first), an optional
// even-parity bit, then a stop condition. Every scl level lasts DIV sclk
// cycles.
//
// Parameters:
//   DATA_W    payload width in bits (>= 1)
//   DIV       scl half-period in sclk cycles (>= 1)
//   MSB_FIRST 1: payload bit DATA_W-1 goes first, 0: bit 0 goes first
//   PAR_EN    1: append even parity (XOR of payload) after the data
//
// Ports:
//   sclk   in   system clock, rising edge
//   rst    in   asynchronous reset, active low
//   data   in   word to send, sampled only on acceptance
//   valid  in   producer has a word on data
//   ready  out  framer accepts a word this cycle
//   scl    out  serial clock (registered)
//   sda    out  serial data (registered)
//   busy   out  frame in progress
//   done   out  one-cycle pulse when the stop condition completes
module ptosda_frame #(
  parameter int DATA_W    = 4,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1,
  parameter int PAR_EN    = 0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              scl,
  output logic              sda,
  output logic              busy,
  output logic              done
);

  localparam int NB = DATA_W + ((PAR_EN != 0) ? 1 : 0);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_BIT_LO  = 3'd2;
  localparam logic [2:0] ST_BIT_HI  = 3'd3;
  localparam logic [2:0] ST_STOP_LO = 3'd4;
  localparam logic [2:0] ST_STOP_HI = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              scl_q, scl_d;
  logic              sda_q, sda_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              phase_end;
  logic [DATA_W-1:0] shift_next;

  // The bit on the wire always comes from the end of the shift register
  // that faces the line; the register moves one place per finished slot.
  function automatic logic head_bit(input logic [DATA_W-1:0] s);
    if (MSB_FIRST != 0) begin
      return s[DATA_W-1];
    end
    return s[0];
  endfunction

  // The last slot carries parity when it is enabled; every other slot
  // carries the current head of the shift register.
  function automatic logic slot_bit(input logic [DATA_W-1:0] s,
                                    input logic [BW-1:0]     idx,
                                    input logic              par);
    if ((PAR_EN != 0) && (idx == BIT_LAST)) begin
      return par;
    end
    return head_bit(s);
  endfunction

  assign phase_end  = (phase_q == PH_LAST);
  assign shift_next = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

  // Next-state logic. Output levels are computed for the state being
  // entered so that scl/sda come straight from flops and change exactly
  // on the phase boundary.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
        if (valid && ready_q) begin
          shift_d = data;
          par_d   = ^data;
          state_d = ST_START;
          phase_d = '0;
          bit_d   = '0;
          sda_d   = 1'b0;
        end
      end

      ST_START: begin
        if (phase_end) begin
          state_d = ST_BIT_LO;
          phase_d = '0;
          scl_d   = 1'b0;
          sda_d   = slot_bit(shift_q, '0, par_q);
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_BIT_LO: begin
        if (phase_end) begin
          state_d = ST_BIT_HI;
          phase_d = '0;
          scl_d   = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_BIT_HI: begin
        if (phase_end) begin
          phase_d = '0;
          scl_d   = 1'b0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP_LO;
            sda_d   = 1'b0;
          end else begin
            // sda moves to the next slot only as scl falls.
            state_d = ST_BIT_LO;
            bit_d   = bit_q + 1'b1;
            shift_d = shift_next;
            sda_d   = slot_bit(shift_next, bit_q + 1'b1, par_q);
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_STOP_LO: begin
        if (phase_end) begin
          state_d = ST_STOP_HI;
          phase_d = '0;
          scl_d   = 1'b1;
          sda_d   = 1'b0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      ST_STOP_HI: begin
        if (phase_end) begin
          // sda rising with scl high is the stop condition.
          state_d = ST_IDLE;
          phase_d = '0;
          bit_d   = '0;
          scl_d   = 1'b1;
          sda_d   = 1'b1;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        bit_d   = '0;
        scl_d   = 1'b1;
        sda_d   = 1'b1;
      end
    endcase

    // ready is registered so it stays low through reset and rises on the
    // first edge after release, and is already high in the done cycle.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign scl   = scl_q;
  assign sda   = sda_q;
  assign ready = ready_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
